// File: rtl/kei_i2c_pkg.sv
// -----------------------------------------------------------------------------
// kei_i2c_pkg
// Shared types and constants for the I2C master transmit path.
//   i2c_tx_cmd_t      : one IC_DATA_CMD write image {restart, stop, read_cmd, data}
//   I2C_TX_FIFO_DEPTH : default number of TX FIFO entries
//   I2C_TX_CMD_W      : bit width of one command entry
// -----------------------------------------------------------------------------
package kei_i2c_pkg;

    localparam int I2C_TX_FIFO_DEPTH = 8;
    localparam int I2C_TX_CMD_W      = 11;

    typedef struct packed {
        logic       restart;
        logic       stop;
        logic       read_cmd;
        logic [7:0] data;
    } i2c_tx_cmd_t;

endpackage

// File: rtl/kei_i2c_fifo_ram.sv
// -----------------------------------------------------------------------------
// kei_i2c_fifo_ram
// DEPTH x 11 storage for the TX FIFO: one synchronous write port, one
// asynchronous read port. Contents are not reset.
//   clk    in  : write clock
//   we     in  : write enable
//   waddr  in  : write address
//   wdata  in  : write data (i2c_tx_cmd_t)
//   raddr  in  : read address
//   rdata  out : combinational read data
// -----------------------------------------------------------------------------
module kei_i2c_fifo_ram
    import kei_i2c_pkg::*;
#(
    parameter int DEPTH = I2C_TX_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  i2c_tx_cmd_t   wdata,
    input  logic [AW-1:0] raddr,
    output i2c_tx_cmd_t   rdata
);

    i2c_tx_cmd_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/kei_i2c_tx_fifo.sv
// -----------------------------------------------------------------------------
// kei_i2c_tx_fifo
// First-word-fall-through TX command FIFO between the register side and the
// I2C master FSM. Pointers are AW+1 bits so that full and empty can be told
// apart without a separate count register.
//
// Build option: define KEI_I2C_TX_FIFO_THR_EN to enable the threshold
// comparator (tx_thr_below = tx_level <= tx_thr). Without it, tx_thr is
// ignored and tx_thr_below is tied low.
//
// Ports
//   clk           in  : clock
//   rstn          in  : asynchronous active-low reset
//   tx_push       in  : write strobe
//   tx_push_data  in  : {restart, stop, read_cmd, data[7:0]}
//   tx_pop        in  : read strobe
//   tx_pop_data   out : head entry, valid while !tx_empty
//   tx_flush      in  : synchronous clear, wins over push/pop
//   tx_thr        in  : threshold level
//   tx_empty      out : no entries
//   tx_full       out : DEPTH entries
//   tx_level      out : entry count
//   tx_thr_below  out : tx_level <= tx_thr
//   tx_over       out : sticky overflow
//   clr_tx_over   in  : clear pulse for tx_over
// -----------------------------------------------------------------------------
module kei_i2c_tx_fifo
    import kei_i2c_pkg::*;
#(
    parameter int DEPTH = I2C_TX_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          tx_push,
    input  logic [10:0]   tx_push_data,
    input  logic          tx_pop,
    output logic [10:0]   tx_pop_data,
    input  logic          tx_flush,
    input  logic [AW:0]   tx_thr,
    output logic          tx_empty,
    output logic          tx_full,
    output logic [AW:0]   tx_level,
    output logic          tx_thr_below,
    output logic          tx_over,
    input  logic          clr_tx_over
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        tx_over_q, tx_over_d;

    logic        empty;
    logic        full;
    logic        pop_ok;
    logic        push_ok;
    logic        over_set;

    i2c_tx_cmd_t push_cmd;
    i2c_tx_cmd_t head_cmd;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop on a full FIFO frees the slot the same-cycle push needs.
    assign pop_ok   = tx_pop && !empty && !tx_flush;
    assign push_ok  = tx_push && (!full || pop_ok) && !tx_flush;
    assign over_set = tx_push && full && !pop_ok && !tx_flush;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        tx_over_d = tx_over_q;
        if (tx_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
        // A new overflow outranks a coincident clear so no event is lost.
        if (over_set) begin
            tx_over_d = 1'b1;
        end else if (clr_tx_over) begin
            tx_over_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tx_over_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tx_over_q <= tx_over_d;
        end
    end

    assign push_cmd = i2c_tx_cmd_t'(tx_push_data);

    kei_i2c_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (push_cmd),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (head_cmd)
    );

    assign tx_pop_data = head_cmd;
    assign tx_empty    = empty;
    assign tx_full     = full;
    // Pointer difference modulo 2*DEPTH is the occupancy (0..DEPTH).
    assign tx_level    = wr_ptr_q - rd_ptr_q;
    assign tx_over     = tx_over_q;

`ifdef KEI_I2C_TX_FIFO_THR_EN
    assign tx_thr_below = (tx_level <= tx_thr);
`else
    logic unused_tx_thr;
    assign unused_tx_thr = ^tx_thr;
    assign tx_thr_below  = 1'b0;
`endif

endmodule

// File: tb/tb_kei_i2c_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_kei_i2c_tx_fifo
// Self-checking bench for kei_i2c_tx_fifo (DEPTH=8). A reference queue holds
// the expected contents; the head is compared whenever the DUT pops and the
// flags/level are compared after every clock.
// -----------------------------------------------------------------------------
module tb_kei_i2c_tx_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk;
    logic          rstn;
    logic          tx_push;
    logic [10:0]   tx_push_data;
    logic          tx_pop;
    logic [10:0]   tx_pop_data;
    logic          tx_flush;
    logic [AW:0]   tx_thr;
    logic          tx_empty;
    logic          tx_full;
    logic [AW:0]   tx_level;
    logic          tx_thr_below;
    logic          tx_over;
    logic          clr_tx_over;

    int            n_checks;
    int            n_fail;
    logic [10:0]   sb_q[$];
    bit            m_over;

    kei_i2c_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .tx_push      (tx_push),
        .tx_push_data (tx_push_data),
        .tx_pop       (tx_pop),
        .tx_pop_data  (tx_pop_data),
        .tx_flush     (tx_flush),
        .tx_thr       (tx_thr),
        .tx_empty     (tx_empty),
        .tx_full      (tx_full),
        .tx_level     (tx_level),
        .tx_thr_below (tx_thr_below),
        .tx_over      (tx_over),
        .clr_tx_over  (clr_tx_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_thr_below();
`ifdef KEI_I2C_TX_FIFO_THR_EN
        return (sb_q.size() <= int'(tx_thr)) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic check_state(input string tag);
        check_val({tag, ".level"}, int'(tx_level), sb_q.size());
        check_val({tag, ".empty"}, int'(tx_empty), (sb_q.size() == 0) ? 1 : 0);
        check_val({tag, ".full"},  int'(tx_full),  (sb_q.size() == DEPTH) ? 1 : 0);
        check_val({tag, ".over"},  int'(tx_over),  int'(m_over));
        check_val({tag, ".thr"},   int'(tx_thr_below), exp_thr_below());
    endtask

    // One clock of stimulus; called at posedge+1, returns at posedge+1.
    task automatic step(input string tag, input bit push, input logic [10:0] data,
                        input bit pop, input bit flush = 1'b0, input bit clr = 1'b0);
        bit pop_ok;
        bit push_ok;
        bit set_over;
        tx_push      = push;
        tx_push_data = data;
        tx_pop       = pop;
        tx_flush     = flush;
        clr_tx_over  = clr;
        #1;
        if (pop && !flush && sb_q.size() > 0) begin
            check_val({tag, ".pop_data"}, int'(tx_pop_data), int'(sb_q[0]));
        end
        @(posedge clk);
        set_over = 1'b0;
        if (flush) begin
            sb_q.delete();
        end else begin
            pop_ok  = pop && (sb_q.size() > 0);
            push_ok = push && ((sb_q.size() < DEPTH) || pop_ok);
            if (pop_ok)  void'(sb_q.pop_front());
            if (push_ok) sb_q.push_back(data);
            if (push && !push_ok) set_over = 1'b1;
        end
        if (set_over)  m_over = 1'b1;
        else if (clr)  m_over = 1'b0;
        #1;
        tx_push     = 1'b0;
        tx_pop      = 1'b0;
        tx_flush    = 1'b0;
        clr_tx_over = 1'b0;
        check_state(tag);
    endtask

    initial begin
        logic [10:0] head_before;
        n_checks     = 0;
        n_fail       = 0;
        m_over       = 1'b0;
        rstn         = 1'b0;
        tx_push      = 1'b0;
        tx_push_data = '0;
        tx_pop       = 1'b0;
        tx_flush     = 1'b0;
        tx_thr       = 4'd2;
        clr_tx_over  = 1'b0;
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        check_state("reset");

        // Basic ordering
        step("p0a5", 1, 11'h0A5, 0);
        step("p1c3", 1, 11'h1C3, 0);
        step("p400", 1, 11'h400, 0);
        repeat (3) step("pop3", 0, '0, 1);

        // Pop on empty is ignored
        step("pop_empty", 0, '0, 1);

        // Overflow: 9 pushes into 8 entries
        for (int i = 1; i <= 9; i++) step("fill9", 1, 11'(i * 16 + 3), 0);
        for (int i = 0; i < 8; i++) step("drain8", 0, '0, 1);
        step("clr_over", 0, '0, 0, 0, 1);

        // Full with simultaneous push+pop
        for (int i = 0; i < 8; i++) step("fill8", 1, 11'(11'h200 + i), 0);
        head_before = tx_pop_data;
        step("full_pp", 1, 11'h3EE, 1);
        check_val("full_pp.head_adv", int'(tx_pop_data), 11'h201);
        check_val("full_pp.head_chg", int'(tx_pop_data != head_before), 1);
        for (int i = 0; i < 8; i++) step("drain_pp", 0, '0, 1);

        // Empty with simultaneous push+pop
        step("empty_pp", 1, 11'h077, 1);
        step("empty_pp_pop", 0, '0, 1);

        // Threshold
        tx_thr = 4'd2;
        step("thr_p1", 1, 11'h011, 0);
        step("thr_p2", 1, 11'h022, 0);
        step("thr_p3", 1, 11'h033, 0);
        step("thr_pop", 0, '0, 1);
        tx_thr = 4'd15;
        for (int i = 0; i < 6; i++) step("thr_big", 1, 11'(11'h150 + i), 0);
        tx_thr = 4'd0;
        step("thr_zero", 0, '0, 0);

        // Flush with concurrent push from level 5
        tx_thr = 4'd4;
        step("pre_flush", 0, '0, 1);
        step("pre_flush", 0, '0, 1);
        step("pre_flush", 0, '0, 1);
        check_val("pre_flush.lvl5", int'(tx_level), 5);
        step("flush_push", 1, 11'h7FF, 0, 1);
        step("after_flush_pop", 0, '0, 1);

        // Overflow concurrent with clear: set wins
        for (int i = 0; i < 8; i++) step("fill_ovc", 1, 11'(11'h0C0 + i), 0);
        step("ovf_clr", 1, 11'h0FF, 0, 0, 1);
        step("clr_only", 0, '0, 0, 0, 1);
        step("flush_keep", 0, '0, 0, 1);
        step("ovf_again", 0, '0, 0, 0, 0);

        // Async reset mid-cycle from level 3
        for (int i = 0; i < 3; i++) step("pre_rst", 1, 11'(11'h0E0 + i), 0);
        step("set_over", 0, '0, 0);
        #2 rstn = 1'b0;
        #1;
        sb_q.delete();
        m_over = 1'b0;
        check_state("async_rst");
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        check_state("rst_rel");
        step("post_rst_push", 1, 11'h2A5, 0);
        check_val("post_rst.mem0", int'(dut.u_ram.mem_q[0]), 11'h2A5);
        step("post_rst_pop", 0, '0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            tx_thr = 4'($urandom_range(0, 15));
            step("rand", bit'($urandom_range(0, 2) != 0), 11'($urandom),
                 bit'($urandom_range(0, 2) == 0),
                 bit'($urandom_range(0, 40) == 0),
                 bit'($urandom_range(0, 10) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kei_i2c_tx_fifo.md
KEI_I2C_TX_FIFO -- requirements
Module: kei_i2c_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, the number of FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), the pointer width.
REQ-003 SHALL have port clk  input  1  the single clock for all logic.
REQ-004 SHALL have port rstn  input  1  reset: asynchronous, active-low.
REQ-005 SHALL have port tx_push  input  1  write strobe from the register/APB side (the backdoor bench also drives it).
REQ-006 SHALL have port tx_push_data  input  11  {restart, stop, read_cmd, data[7:0]} (IC_DATA_CMD write image).
REQ-007 SHALL have port tx_pop  input  1  read strobe from the master FSM.
REQ-008 SHALL have port tx_pop_data  output  11  head entry, first-word-fall-through.
REQ-009 SHALL have port tx_flush  input  1  synchronous clear (abort / enable deassert).
REQ-010 SHALL have port tx_thr  input  AW+1  threshold level.
REQ-011 SHALL have port tx_empty, tx_full  output  1 each  occupancy flags.
REQ-012 SHALL have port tx_level  output  AW+1  current entry count.
REQ-013 SHALL have port tx_thr_below  output  1  level <= tx_thr.
REQ-014 SHALL have port tx_over  output  1  sticky overflow flag.
REQ-015 SHALL have port clr_tx_over  input  1  one-cycle pulse that clears tx_over.

Function
REQ-016 SHALL hold read/write pointers of AW+1 bits each; empty = pointers equal; full = MSBs differ and low bits equal.
REQ-017 SHALL register an accepted push at the clk edge; tx_level and the flags update in the same edge.
REQ-018 SHALL drive tx_pop_data combinationally from mem[rd_ptr]; the value is valid only while !tx_empty.
REQ-019 SHALL, on push while full and no pop, drop the data, leave pointers unchanged and set tx_over.
REQ-020 SHALL ignore a pop while empty: no pointer move and no flag.
REQ-021 SHALL, on simultaneous push+pop while full, accept both; level stays DEPTH and tx_over is not set.
REQ-022 SHALL, on simultaneous push+pop while empty, accept the push only; level becomes 1.
REQ-023 SHALL wrap pointers modulo 2*DEPTH with no special handling.
REQ-024 SHALL give tx_flush priority over push/pop that cycle: pointers go to 0 and the entry pushed that cycle is discarded; tx_over is unaffected.
REQ-025 SHALL make tx_over set dominate clr_tx_over when both occur in the same cycle.
REQ-026 SHALL compute tx_thr_below combinationally from the registered tx_level; tx_thr > DEPTH means the flag is always 1.

Reset
REQ-027 SHALL, with rstn low, asynchronously force pointers=0, tx_level=0, tx_empty=1, tx_full=0, tx_over=0 and tx_thr_below=1.
REQ-028 SHALL NOT reset memory contents; tx_pop_data is don't-care while empty.
REQ-029 SHALL, on reset asserted mid-operation, discard all entries immediately; first push after release goes to mem[0].

Configuration
REQ-030 SHALL use macro KEI_I2C_TX_FIFO_THR_EN to control threshold logic.
REQ-031 SHALL, when the macro is defined, implement tx_thr_below per REQ-026.
REQ-032 SHALL, when the macro is undefined, ignore tx_thr, tie tx_thr_below to 0 and synthesise no comparator.

Structure
REQ-033 SHALL place typedef struct packed {restart, stop, read_cmd, data[7:0]} i2c_tx_cmd_t and localparam I2C_TX_FIFO_DEPTH=8 in package kei_i2c_pkg.
REQ-034 SHALL instantiate one sub-module kei_i2c_fifo_ram (DEPTH x 11, 1W/1R, async read); all pointer/flag logic stays in kei_i2c_tx_fifo.

Verification
REQ-035 SHALL cover: after reset, push 0x0A5, 0x1C3, 0x400, then pop x3 -> tx_pop_data 0x0A5, 0x1C3, 0x400 in order; tx_empty=1, tx_level=0.
REQ-036 SHALL cover: push 9 words into DEPTH=8 -> tx_full=1 after 8th; 9th dropped, tx_over=1; pop x8 returns words 1..8.
REQ-037 SHALL cover: fill to 8, then push+pop same cycle -> level stays 8, tx_over=0, head advances by one.
REQ-038 SHALL cover: tx_thr=2, push 3 -> tx_thr_below 1,1,0 after each push; pop 1 -> back to 1 (macro defined); macro undefined -> always 0.
REQ-039 SHALL cover: level 5, tx_flush with tx_push same cycle -> level 0, tx_empty=1; clr_tx_over with concurrent overflow -> tx_over stays 1.
REQ-040 SHALL cover: level 3, rstn pulsed low mid-cycle -> flags reset without a clk edge; next push lands at entry 0 and pops back intact.
